// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the latency counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the memory stage (master) and the
// data-memory responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store masks/replication, load extraction
// with RV32I sign/zero extension, funct3 legality and misalignment detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        isStore,
    input  logic [1:0]  addrLo,
    input  logic [31:0] storeData,
    input  logic [31:0] readWord,
    output logic [3:0]  byteMask,
    output logic [31:0] writeData,
    output logic [31:0] loadData,
    output logic        funct3Illegal,
    output logic        misalign
);

    logic [7:0]  lanes [4];
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = readWord[gi*8 +: 8];
        end
    endgenerate

    assign selByte = lanes[addrLo];
    assign selHalf = addrLo[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        byteMask      = 4'b0000;
        writeData     = storeData;
        loadData      = 32'd0;
        funct3Illegal = 1'b0;
        misalign      = 1'b0;
        case (funct3)
            F3_B: begin
                byteMask  = 4'b0001 << addrLo;
                writeData = {4{storeData[7:0]}};
                loadData  = {{24{selByte[7]}}, selByte};
            end
            F3_H: begin
                byteMask  = addrLo[1] ? 4'b1100 : 4'b0011;
                writeData = {2{storeData[15:0]}};
                loadData  = {{16{selHalf[15]}}, selHalf};
                misalign  = addrLo[0];
            end
            F3_W: begin
                byteMask  = 4'b1111;
                loadData  = readWord;
                misalign  = |addrLo;
            end
            // Unsigned forms exist only for loads.
            F3_BU: begin
                funct3Illegal = isStore;
                loadData      = {24'd0, selByte};
            end
            F3_HU: begin
                funct3Illegal = isStore;
                loadData      = {16'd0, selHalf};
                misalign      = addrLo[0];
            end
            default: funct3Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable latency, byte/half/
// word access. Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmemState_e        stateReg, stateNext;
    logic [CNT_W-1:0]  cntReg, cntNext;
    logic [31:0]       respRdataReg, respRdataNext;
    logic              respErrReg, respErrNext;
    logic              weReg, weNext;
    logic [2:0]        funct3Reg, funct3Next;
    logic [1:0]        addrLoReg, addrLoNext;
    logic [IDX_W-1:0]  idxReg, idxNext;
    logic [31:0]       wdataReg, wdataNext;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rdWordReg;

    logic              accept;
    logic              execute;
    logic              accessErr;
    logic              commitWrite;
    logic [IDX_W-1:0]  reqIdx;
    logic [3:0]        byteMask;
    logic [31:0]       writeData;
    logic [31:0]       loadData;
    logic              funct3Illegal;
    logic              misalign;

    assign bus.req_ready  = (stateReg == IDLE) && rst;
    assign bus.resp_valid = (stateReg == RESP);
    assign bus.resp_rdata = respRdataReg;
    assign bus.resp_err   = respErrReg;

    assign accept  = bus.req_valid && bus.req_ready;
    assign execute = (stateReg == WAIT) && (cntReg == '0);
    assign reqIdx  = bus.req_addr[IDX_W+1:2];

    dmem_lane_align u_align (
        .funct3        (funct3Reg),
        .isStore       (weReg),
        .addrLo        (addrLoReg),
        .storeData     (wdataReg),
        .readWord      (rdWordReg),
        .byteMask      (byteMask),
        .writeData     (writeData),
        .loadData      (loadData),
        .funct3Illegal (funct3Illegal),
        .misalign      (misalign)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign accessErr = funct3Illegal || misalign;
    logic unusedBits;
    assign unusedBits = &{1'b0, bus.req_addr[31:IDX_W+2]};
`else
    assign accessErr = funct3Illegal;
    logic unusedBits;
    assign unusedBits = &{1'b0, bus.req_addr[31:IDX_W+2], misalign};
`endif

    assign commitWrite = execute && weReg && !accessErr;

    // The word is fetched at the accept edge, so it is ready even for LATENCY=1.
    always_ff @(posedge clk) begin
        if (accept) begin
            rdWordReg <= mem[reqIdx];
        end
        if (commitWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteMask[b]) begin
                    mem[idxReg][b*8 +: 8] <= writeData[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            respRdataReg <= 32'd0;
            respErrReg   <= 1'b0;
            weReg        <= 1'b0;
            funct3Reg    <= 3'd0;
            addrLoReg    <= 2'd0;
            idxReg       <= '0;
            wdataReg     <= 32'd0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            respRdataReg <= respRdataNext;
            respErrReg   <= respErrNext;
            weReg        <= weNext;
            funct3Reg    <= funct3Next;
            addrLoReg    <= addrLoNext;
            idxReg       <= idxNext;
            wdataReg     <= wdataNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        respRdataNext = respRdataReg;
        respErrNext   = respErrReg;
        weNext        = weReg;
        funct3Next    = funct3Reg;
        addrLoNext    = addrLoReg;
        idxNext       = idxReg;
        wdataNext     = wdataReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    stateNext  = WAIT;
                    cntNext    = CNT_W'(LATENCY - 1);
                    weNext     = bus.req_we;
                    funct3Next = bus.req_funct3;
                    addrLoNext = bus.req_addr[1:0];
                    idxNext    = reqIdx;
                    wdataNext  = bus.req_wdata;
                end
            end
            WAIT: begin
                if (cntReg == '0) begin
                    stateNext     = RESP;
                    respErrNext   = accessErr;
                    respRdataNext = (accessErr || weReg) ? 32'd0 : loadData;
                end else begin
                    cntNext = cntReg - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target answering the pipeline's memory-stage load/store requests: address, write data, funct3 size/sign, load/store strobes.
- Accepts one request at a time on a valid/ready handshake and waits a programmable latency.
- Performs byte/half/word access with RV32I sign/zero extension, then returns a response on a second valid/ready channel.
- Sits between the memory stage and backing storage; it is the responder end of the pipeline's data-access interface.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the storage array (power of two, >=4)
LATENCY, 2, cycles from request acceptance to resp_valid (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3 (or misaligned, see feature)

Behaviour:
- Reset (rst=0, async): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. req_ready=0 while rst=0. Memory contents are not reset.
- req_ready = (state==IDLE) && rst. Acceptance occurs when req_valid && req_ready at a rising edge; req_addr, req_we, req_funct3 and req_wdata are captured.
- States and transitions:
  - IDLE -> WAIT on acceptance, with counter=LATENCY-1.
  - WAIT: counter decrements each cycle. When counter==0, the access executes at that edge and the state goes to RESP.
  - LATENCY=1: IDLE -> WAIT with counter 0, so resp_valid rises exactly LATENCY edges after the accept edge.
  - RESP: resp_valid=1; resp_rdata and resp_err hold stable until resp_valid && resp_ready at an edge, then -> IDLE.
  - The response-handshake edge does not also accept a request, so back-to-back throughput is one request per LATENCY+2 cycles.
- Addressing: word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (wrap-around). Byte lane = addr[1:0].
- Loads:
  - 000 LB: byte at lane, sign-extended.
  - 001 LH: half at addr[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: zero-extended.
  - Any other funct3: resp_err=1, resp_rdata=0.
- Stores:
  - 000 SB writes byte lane addr[1:0] with wdata[7:0].
  - 001 SH writes half addr[1] with wdata[15:0].
  - 010 SW writes the full word.
  - Any other funct3: resp_err=1 and no write.
  - Stores return resp_rdata=0.
- Store commits at the WAIT->RESP edge only. Reset asserted before that edge drops the transaction with no write. Reset asserted in RESP discards the response; the write remains.
- The input bus is ignored outside IDLE. resp_ready is ignored outside RESP.
- Without the optional feature, misalignment is not checked: LH/SH use addr[1] and ignore addr[0]; LW/SW ignore addr[1:0].

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, produces resp_err=1, resp_rdata=0, and no memory write. Timing is unchanged.
- Undefined: aligned-down behaviour as above; resp_err only for illegal funct3.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/WAIT/RESP.
  - Counter width localparam (4 bits).
- One sub-module, dmem_lane_align (combinational). Inputs: funct3, addr[1:0], store data, read word. Outputs: 4-bit byte write mask, lane-shifted write data, extended load data, funct3-illegal flag, misalign flag.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF; LW 0x10 -> resp_rdata=0xDEADBEEF, err=0. resp_valid rises exactly LATENCY edges after each accept.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55 over 0xDEADBEEF; LW 0x10 -> 0xDEAD55EF.
- Store funct3=011 to 0x20 (prior 0x12345678) -> err=1, rdata=0; LW 0x20 -> 0x12345678. Load funct3=110 -> err=1.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0. Then resp_ready=1 -> IDLE next cycle.
- SW 0x40 with rst pulsed low during WAIT -> outputs zero immediately, no write (LW 0x40 returns prior value). With DMEM_MISALIGN_TRAP_EN, LW 0x42 -> err=1; without it, returns the word at 0x40.
